// File: rtl/snoop_bus_arbiter.sv
// Snoop bus arbiter: grants one cache at a time in round-robin order, broadcasts
// its snoop, collects hit/flush responses from the other caches and falls back
// to memory (with a timeout) when no cache can supply the line.
module snoop_bus_arbiter #(
  parameter int NUM_CORES   = 4,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        req,
  input  logic [2*NUM_CORES-1:0]      op_in,
  input  logic [ADDR_W*NUM_CORES-1:0] addr_in,
  input  logic [NUM_CORES-1:0]        hit_in,
  input  logic [NUM_CORES-1:0]        flush_in,
  input  logic [DATA_W*NUM_CORES-1:0] data_in,
  output logic [NUM_CORES-1:0]        grant,
  output logic                        snoop_valid,
  output logic [1:0]                  snoop_op,
  output logic [ADDR_W-1:0]           snoop_addr,
  output logic [NUM_CORES-1:0]        done,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_shared,
  output logic                        resp_err,
  output logic                        mem_req,
  output logic [ADDR_W-1:0]           mem_addr,
  input  logic                        mem_ack,
  input  logic [DATA_W-1:0]           mem_data
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [1:0] OP_UPGR = 2'b01;
  localparam logic [1:0] OP_NONE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNOOP,
    S_RESP,
    S_MEM,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [IDX_W-1:0]      r_lastGrant;
  logic [IDX_W-1:0]      r_curIdx;
  logic [NUM_CORES-1:0]  r_grant;
  logic                  r_snoopValid;
  logic [1:0]            r_snoopOp;
  logic [ADDR_W-1:0]     r_snoopAddr;
  logic [NUM_CORES-1:0]  r_done;
  logic [DATA_W-1:0]     r_respData;
  logic                  r_respShared;
  logic                  r_respErr;
  logic                  r_memReq;
  logic [ADDR_W-1:0]     r_memAddr;
  logic [CNT_W-1:0]      r_memCnt;

  logic                  w_found;
  logic [IDX_W-1:0]      w_nextIdx;
  logic [IDX_W:0]        w_cand;
  logic [1:0]            w_reqOp;
  logic [ADDR_W-1:0]     w_reqAddr;
  logic [NUM_CORES-1:0]  w_hitOthers;
  logic [NUM_CORES-1:0]  w_flushOthers;
  logic [IDX_W-1:0]      w_flushIdx;
  logic                  w_multiFlush;
  logic [DATA_W-1:0]     w_flushData;

  assign grant       = r_grant;
  assign snoop_valid = r_snoopValid;
  assign snoop_op    = r_snoopOp;
  assign snoop_addr  = r_snoopAddr;
  assign done        = r_done;
  assign resp_data   = r_respData;
  assign resp_shared = r_respShared;
  assign resp_err    = r_respErr;
  assign mem_req     = r_memReq;
  assign mem_addr    = r_memAddr;

  // Round-robin search: first requesting core starting one past the last winner.
  always_comb begin
    w_found   = 1'b0;
    w_nextIdx = '0;
    w_cand    = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_cand = {1'b0, r_lastGrant} + (IDX_W+1)'(i + 1);
      if (w_cand >= (IDX_W+1)'(NUM_CORES)) begin
        w_cand = w_cand - (IDX_W+1)'(NUM_CORES);
      end
      if (!w_found && req[w_cand[IDX_W-1:0]]) begin
        w_found   = 1'b1;
        w_nextIdx = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_reqOp   = op_in[2*int'(w_nextIdx) +: 2];
  assign w_reqAddr = addr_in[ADDR_W*int'(w_nextIdx) +: ADDR_W];

  // The requester never answers its own snoop, so mask it out of the responses.
  assign w_hitOthers   = hit_in & ~r_grant;
  assign w_flushOthers = flush_in & ~r_grant;
  assign w_multiFlush  = (w_flushOthers & (w_flushOthers - NUM_CORES'(1))) != '0;

  // Lowest-index flushing core supplies the data when several flush at once.
  always_comb begin
    w_flushIdx = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (w_flushOthers[i]) begin
        w_flushIdx = IDX_W'(i);
      end
    end
  end

  assign w_flushData = data_in[DATA_W*int'(w_flushIdx) +: DATA_W];

  // Transaction FSM with all bus-visible outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_lastGrant  <= IDX_W'(NUM_CORES - 1);
      r_curIdx     <= '0;
      r_grant      <= '0;
      r_snoopValid <= 1'b0;
      r_snoopOp    <= '0;
      r_snoopAddr  <= '0;
      r_done       <= '0;
      r_respData   <= '0;
      r_respShared <= 1'b0;
      r_respErr    <= 1'b0;
      r_memReq     <= 1'b0;
      r_memAddr    <= '0;
      r_memCnt     <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant      <= NUM_CORES'(1) << w_nextIdx;
            r_curIdx     <= w_nextIdx;
            r_snoopOp    <= w_reqOp;
            r_snoopAddr  <= w_reqAddr;
            r_respData   <= '0;
            r_respShared <= 1'b0;
            r_respErr    <= 1'b0;
            if (w_reqOp == OP_NONE) begin
              r_state <= S_DONE;
            end else begin
              r_snoopValid <= 1'b1;
              r_state      <= S_SNOOP;
            end
          end
        end
        S_SNOOP: begin
          r_snoopValid <= 1'b0;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_respShared <= |w_hitOthers;
          if (r_snoopOp == OP_UPGR) begin
            r_respData <= '0;
            r_done     <= r_grant;
            r_state    <= S_DONE;
          end else if (|w_flushOthers) begin
            r_respData <= w_flushData;
            r_respErr  <= w_multiFlush;
            r_done     <= r_grant;
            r_state    <= S_DONE;
          end else begin
            r_memReq  <= 1'b1;
            r_memAddr <= r_snoopAddr;
            r_memCnt  <= '0;
            r_state   <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            r_respData <= mem_data;
            r_memReq   <= 1'b0;
            r_memAddr  <= '0;
            r_done     <= r_grant;
            r_state    <= S_DONE;
          end else if (r_memCnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            r_respErr  <= 1'b1;
            r_respData <= '0;
            r_memReq   <= 1'b0;
            r_memAddr  <= '0;
            r_done     <= r_grant;
            r_state    <= S_DONE;
          end else begin
            r_memCnt <= r_memCnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          r_grant     <= '0;
          r_lastGrant <= r_curIdx;
          r_memCnt    <= '0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter: round-robin order, cache flush, memory
// fill, memory timeout and its boundary, upgrade, null op, multi-flush and reset.
module tb_snoop_bus_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 15;

  logic              clk;
  logic              reset;
  logic [NC-1:0]     req;
  logic [2*NC-1:0]   op_in;
  logic [AW*NC-1:0]  addr_in;
  logic [NC-1:0]     hit_in;
  logic [NC-1:0]     flush_in;
  logic [DW*NC-1:0]  data_in;
  logic [NC-1:0]     grant;
  logic              snoop_valid;
  logic [1:0]        snoop_op;
  logic [AW-1:0]     snoop_addr;
  logic [NC-1:0]     done;
  logic [DW-1:0]     resp_data;
  logic              resp_shared;
  logic              resp_err;
  logic              mem_req;
  logic [AW-1:0]     mem_addr;
  logic              mem_ack;
  logic [DW-1:0]     mem_data;

  int   passCount  = 0;
  int   checkCount = 0;
  int   cyc;
  logic memSeen;

  snoop_bus_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .op_in(op_in), .addr_in(addr_in),
    .hit_in(hit_in), .flush_in(flush_in), .data_in(data_in), .grant(grant),
    .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
    .done(done), .resp_data(resp_data), .resp_shared(resp_shared),
    .resp_err(resp_err), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_data(mem_data)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait loop is ever broken.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [NC-1:0] r, input logic [2*NC-1:0] o,
                               input logic [NC-1:0] h, input logic [NC-1:0] f);
    req      = r;
    op_in    = o;
    hit_in   = h;
    flush_in = f;
  endtask

  task automatic waitGrant(input int budget, output int cycles);
    cycles = 0;
    while (grant == '0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic waitMem(input int budget, output int cycles);
    cycles = 0;
    while (!mem_req && cycles < budget) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic waitDone(input int budget, output int cycles, output logic seenMem);
    cycles  = 0;
    seenMem = mem_req;
    while (done == '0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      seenMem = seenMem | mem_req;
    end
  endtask

  // Linear directed sequence; inputs change and outputs are sampled on negedges.
  initial begin
    reset    = 1'b0;
    mem_ack  = 1'b0;
    mem_data = '0;
    addr_in  = '0;
    data_in  = '0;
    applyStimulus('0, '1, '0, '0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_grant", grant, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_snoopValid", snoop_valid, 0);
    checkOutput("rst_memReq", mem_req, 0);
    checkOutput("rst_respData", resp_data, 0);
    reset = 1'b1;

    // Round robin with all cores requesting upgrades: 0,1,2,3,0.
    applyStimulus(4'b1111, 8'b01010101, '0, '0);
    for (int t = 0; t < 5; t++) begin
      waitGrant(10, cyc);
      checkOutput($sformatf("rr_grant%0d", t), grant, 64'd1 << (t % 4));
      if (t == 4) req = '0;
      waitDone(10, cyc, memSeen);
      if (t == 0) checkOutput("rr_latency", cyc, 2);
      checkOutput($sformatf("rr_done%0d", t), done, 64'd1 << (t % 4));
      checkOutput($sformatf("rr_grantHold%0d", t), grant, 64'd1 << (t % 4));
      @(negedge clk);
      checkOutput($sformatf("rr_grantDrop%0d", t), grant, 0);
    end

    // Core1 BusRd, core3 flushes; core1's own hit/flush must be ignored.
    addr_in[AW*1 +: AW] = 32'h0000_0100;
    data_in[DW*3 +: DW] = 32'hDEAD_BEEF;
    data_in[DW*1 +: DW] = 32'hBAD0_BAD0;
    applyStimulus(4'b0010, 8'b11110011, 4'b1010, 4'b1010);
    waitGrant(10, cyc);
    checkOutput("flush_grant", grant, 4'b0010);
    checkOutput("flush_snoopValid", snoop_valid, 1);
    checkOutput("flush_snoopOp", snoop_op, 2'b00);
    checkOutput("flush_snoopAddr", snoop_addr, 32'h100);
    req = '0;
    waitDone(10, cyc, memSeen);
    checkOutput("flush_latency", cyc, 2);
    checkOutput("flush_done", done, 4'b0010);
    checkOutput("flush_data", resp_data, 32'hDEAD_BEEF);
    checkOutput("flush_shared", resp_shared, 1);
    checkOutput("flush_err", resp_err, 0);
    checkOutput("flush_noMem", memSeen, 0);
    @(negedge clk);
    applyStimulus('0, '1, '0, '0);

    // Core0 BusRdX, no hits, memory answers on the third MEM cycle.
    addr_in[AW*0 +: AW] = 32'h0000_0200;
    applyStimulus(4'b0001, 8'b11111110, '0, '0);
    waitGrant(10, cyc);
    checkOutput("mem_grant", grant, 4'b0001);
    req = '0;
    waitMem(10, cyc);
    checkOutput("mem_req", mem_req, 1);
    checkOutput("mem_addr", mem_addr, 32'h200);
    @(negedge clk);
    @(negedge clk);
    checkOutput("mem_hold", mem_req, 1);
    mem_ack  = 1'b1;
    mem_data = 32'h1234_5678;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("mem_done", done, 4'b0001);
    checkOutput("mem_data", resp_data, 32'h1234_5678);
    checkOutput("mem_shared", resp_shared, 0);
    checkOutput("mem_err", resp_err, 0);
    checkOutput("mem_reqDrop", mem_req, 0);
    @(negedge clk);

    // Core2 BusRd, memory never answers: timeout after MEM_TIMEOUT cycles.
    addr_in[AW*2 +: AW] = 32'h0000_0300;
    mem_data = 32'hFFFF_FFFF;
    applyStimulus(4'b0100, 8'b11001111, '0, '0);
    waitGrant(10, cyc);
    checkOutput("to_grant", grant, 4'b0100);
    req = '0;
    waitMem(10, cyc);
    checkOutput("to_memAddr", mem_addr, 32'h300);
    cyc = 0;
    while (done == '0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("to_latency", cyc, TO);
    checkOutput("to_done", done, 4'b0100);
    checkOutput("to_err", resp_err, 1);
    checkOutput("to_data", resp_data, 0);
    checkOutput("to_memReqDrop", mem_req, 0);
    @(negedge clk);

    // Core3 BusRd, ack arrives on the very last allowed MEM cycle and wins.
    addr_in[AW*3 +: AW] = 32'h0000_0400;
    applyStimulus(4'b1000, 8'b00111111, '0, '0);
    waitGrant(10, cyc);
    checkOutput("edge_grant", grant, 4'b1000);
    req = '0;
    waitMem(10, cyc);
    repeat (TO - 1) @(negedge clk);
    checkOutput("edge_memLast", mem_req, 1);
    mem_ack  = 1'b1;
    mem_data = 32'hA5A5_A5A5;
    @(negedge clk);
    mem_ack = 1'b0;
    checkOutput("edge_done", done, 4'b1000);
    checkOutput("edge_err", resp_err, 0);
    checkOutput("edge_data", resp_data, 32'hA5A5_A5A5);
    @(negedge clk);

    // Core1 BusUpgr while core0 hits (and flushes): data stays zero.
    data_in[DW*0 +: DW] = 32'h1111_1111;
    applyStimulus(4'b0010, 8'b11110111, 4'b0001, 4'b0001);
    waitGrant(10, cyc);
    checkOutput("upg_grant", grant, 4'b0010);
    checkOutput("upg_snoopOp", snoop_op, 2'b01);
    req = '0;
    waitDone(10, cyc, memSeen);
    checkOutput("upg_latency", cyc, 2);
    checkOutput("upg_done", done, 4'b0010);
    checkOutput("upg_data", resp_data, 0);
    checkOutput("upg_shared", resp_shared, 1);
    checkOutput("upg_noMem", memSeen, 0);
    @(negedge clk);
    applyStimulus('0, '1, '0, '0);

    // Core2 null op: granted for one cycle, no snoop, no done, pointer moves.
    applyStimulus(4'b0100, 8'b11111111, '0, '0);
    waitGrant(10, cyc);
    checkOutput("nop_grant", grant, 4'b0100);
    checkOutput("nop_snoopValid", snoop_valid, 0);
    checkOutput("nop_noDone", done, 0);
    applyStimulus(4'b0110, 8'b11010111, '0, '0);
    @(negedge clk);
    checkOutput("nop_grantDrop", grant, 0);
    checkOutput("nop_noDoneLater", done, 0);
    waitGrant(10, cyc);
    checkOutput("nop_nextGrant", grant, 4'b0010);
    req = '0;
    waitDone(10, cyc, memSeen);
    checkOutput("nop_nextDone", done, 4'b0010);
    @(negedge clk);

    // Core0 BusRd with cores 2 and 3 both flushing: lowest wins, error flagged.
    data_in[DW*2 +: DW] = 32'h2222_2222;
    data_in[DW*3 +: DW] = 32'h3333_3333;
    applyStimulus(4'b0001, 8'b11111100, 4'b0100, 4'b1100);
    waitGrant(10, cyc);
    checkOutput("multi_grant", grant, 4'b0001);
    req = '0;
    waitDone(10, cyc, memSeen);
    checkOutput("multi_done", done, 4'b0001);
    checkOutput("multi_data", resp_data, 32'h2222_2222);
    checkOutput("multi_err", resp_err, 1);
    checkOutput("multi_shared", resp_shared, 1);
    checkOutput("multi_noMem", memSeen, 0);
    @(negedge clk);
    applyStimulus('0, '1, '0, '0);

    // Reset in the middle of a memory wait, then core1 must win first.
    mem_data = '0;
    applyStimulus(4'b0100, 8'b11001111, '0, '0);
    waitGrant(10, cyc);
    checkOutput("rstm_grant", grant, 4'b0100);
    waitMem(10, cyc);
    checkOutput("rstm_inMem", mem_req, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rstm_grant0", grant, 0);
    checkOutput("rstm_memReq0", mem_req, 0);
    checkOutput("rstm_memAddr0", mem_addr, 0);
    checkOutput("rstm_snoopAddr0", snoop_addr, 0);
    checkOutput("rstm_respErr0", resp_err, 0);
    checkOutput("rstm_respData0", resp_data, 0);
    applyStimulus(4'b0110, 8'b11010111, '0, '0);
    @(negedge clk);
    checkOutput("rstm_doneHeld0", done, 0);
    reset = 1'b1;
    waitGrant(10, cyc);
    checkOutput("rstm_firstGrant", grant, 4'b0010);
    req = '0;
    waitDone(10, cyc, memSeen);
    checkOutput("rstm_firstDone", done, 4'b0010);
    @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/snoop_bus_arbiter.md
SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of cache ports (legal range 2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, bus address width.
REQ-003 SHALL have parameter DATA_W, default 32, bus data width.
REQ-004 SHALL have parameter MEM_TIMEOUT, default 15, maximum number of cycles spent waiting for mem_ack.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1; the reset is asynchronous and active-low.
REQ-007 SHALL have port req, input, NUM_CORES; per-core bus request, level.
REQ-008 SHALL have port op_in, input, 2*NUM_CORES; per-core op: 00 BusRd, 01 BusUpgr, 10 BusRdX, 11 none.
REQ-009 SHALL have port addr_in, input, ADDR_W*NUM_CORES; per-core request address.
REQ-010 SHALL have port hit_in, input, NUM_CORES; per-core snoop hit.
REQ-011 SHALL have port flush_in, input, NUM_CORES; per-core snoop hit on a Modified line, with data valid.
REQ-012 SHALL have port data_in, input, DATA_W*NUM_CORES; per-core snoop/flush data.
REQ-013 SHALL have port grant, output, NUM_CORES; one-hot (or zero) grant.
REQ-014 SHALL have ports snoop_valid (output, 1), snoop_op (output, 2) and snoop_addr (output, ADDR_W); broadcast to all caches.
REQ-015 SHALL have ports done (output, NUM_CORES) and resp_data (output, DATA_W); done is a one-hot completion pulse.
REQ-016 SHALL have ports resp_shared (output, 1), meaning another cache holds the line, and resp_err (output, 1), meaning memory timed out.
REQ-017 SHALL have ports mem_req (output, 1), mem_addr (output, ADDR_W), mem_ack (input, 1) and mem_data (input, DATA_W).

Function
REQ-018 SHALL implement FSM IDLE -> SNOOP -> RESP -> {MEM} -> DONE -> IDLE.
REQ-019 IDLE with req==0 SHALL stay in IDLE with grant=0.
REQ-020 IDLE with any req bit set SHALL grant round-robin: search starts at last_grant+1 modulo NUM_CORES.
REQ-021 IDLE SHALL register the granted core's op and address, then go to SNOOP.
REQ-022 grant SHALL stay stable from the grant cycle through DONE; changes on req are ignored during that time.
REQ-023 A granted request with op 11 SHALL go straight to DONE with no snoop and no done pulse, and last_grant SHALL still update.
REQ-024 SNOOP (1 cycle): snoop_valid=1; snoop_op/snoop_addr carry the latched values.
REQ-025 In SNOOP, the requester SHALL be excluded from every hit_in/flush_in evaluation.
REQ-026 RESP SHALL sample hit_in/flush_in; resp_shared = OR of hit_in over non-requesters.
REQ-027 RESP with op BusUpgr SHALL go to DONE with resp_data=0.
REQ-028 RESP with BusRd/BusRdX and any non-requester flush_in SHALL set resp_data from the lowest-index such core, then go to DONE.
REQ-029 RESP with BusRd/BusRdX and no flush SHALL go to MEM.
REQ-030 MEM SHALL hold mem_req=1 with mem_addr = latched address.
REQ-031 MEM on mem_ack SHALL latch mem_data into resp_data and go to DONE.
REQ-032 MEM SHALL count cycles; reaching MEM_TIMEOUT without mem_ack SHALL set resp_err=1, resp_data=0, and go to DONE.
REQ-033 mem_ack in the same cycle as the timeout SHALL win, giving resp_err=0.
REQ-034 DONE (1 cycle): done[granted]=1; resp_data, resp_shared and resp_err valid.
REQ-035 DONE SHALL update last_grant and drop grant; the next arbitration happens in the following IDLE cycle.
REQ-036 Worst-case latency from grant SHALL be 3 cycles (flush/upgrade) or 3+MEM_TIMEOUT cycles.
REQ-037 Multiple flush_in from non-requesters SHALL be treated as a protocol error: use the lowest index and set resp_err=1.

Reset
REQ-038 reset low SHALL asynchronously force state IDLE and last_grant=NUM_CORES-1, so core 0 has first priority.
REQ-039 reset low SHALL force grant, done, snoop_valid, snoop_op, snoop_addr, resp_*, mem_req, mem_addr and the timeout counter to 0.
REQ-040 reset asserted mid-transaction SHALL abort it with no done pulse; after release, the FSM resumes from IDLE.

Verification
REQ-041 NUM_CORES=4, req=4'b1111 held: grants SHALL be 0,1,2,3,0, each grant lasting until its done.
REQ-042 Core1 BusRd addr 0x100; core3 flush_in=1 with data 0xDEADBEEF: done[1] in the 3rd cycle after grant, resp_data=0xDEADBEEF, resp_shared=1, mem_req never asserted.
REQ-043 Core0 BusRdX with no hits, mem_ack 2 cycles after mem_req with mem_data 0x12345678: resp_data=0x12345678, resp_shared=0, resp_err=0.
REQ-044 Core2 BusRd with mem_ack never asserted: resp_err=1 and done[2] exactly MEM_TIMEOUT cycles after MEM entry.
REQ-045 Core1 BusUpgr while core0 hit_in=1: snoop_op=01, done[1] with resp_data=0 and resp_shared=1.
REQ-046 Assert reset while in MEM: all outputs 0 immediately; after release with req=4'b0110, core1 is granted first.
